rng_word_packer: RTL and testbench

- Downstream consumer of the free-running 8-bit random byte generator.
- On request, collects a programmed number of 32-bit words by sampling the byte stream, with optional decimation and XOR whitening.
- Buffers the words in a small synchronous FIFO and hands them out over a valid/ready interface to the bus-side consumer.
- Reports completion with a done pulse once every requested word has been consumed.

---
 rtl/rng_pkg.sv | 6 +
 rtl/rng_sync_fifo.sv | 52 +++++
 rtl/rng_word_packer.sv | 129 ++++++++++++
 tb/tb_rng_word_packer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared FSM states and word geometry for the RNG word packer.
package rng_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DRAIN = 2'd2} state_t;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W = 32;
endpackage

// File: rtl/rng_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; the head word is visible with no read latency.
// A push is accepted when not full or when a pop happens in the same cycle; a pop on empty is ignored.
module rng_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (level == '0);
    assign full      = (level == (AW+1)'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/rng_word_packer.sv
// Packs sampled (optionally decimated/whitened) RNG bytes little-endian into words queued in a FIFO.
// Latency: first out_valid 4*DECIM cycles after start; a full FIFO freezes sampling until a slot frees.
module rng_word_packer
    import rng_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DECIM   = 1,
    parameter int WHITEN  = 0,
    parameter int WORDS_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rand_in,
    input  logic                   start,
    input  logic [WORDS_W-1:0]     req_words,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic [WORD_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int            DW         = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DW-1:0] DECIM_LAST = DW'(DECIM - 1);

    state_t             state;
    logic [WORDS_W-1:0] remaining;
    logic [1:0]         byte_idx;
    logic [DW-1:0]      decim_cnt;
    logic [7:0]         prev_byte;
    logic [WORD_W-1:0]  pack;
    logic               held;

    logic               collecting;
    logic               sample;
    logic               last_byte;
    logic               word_vld;
    logic               push;
    logic               pop;
    logic               flush;
    logic               fifo_empty;
    logic               fifo_full;
    logic [7:0]         samp_byte;
    logic [WORD_W-1:0]  word_dat;
    logic [WORD_W-1:0]  head_dat;

    assign collecting = (state == COLLECT) && !abort;
    assign sample     = collecting && !held && (decim_cnt == DECIM_LAST);
    assign last_byte  = (byte_idx == 2'(BYTES_PER_WORD - 1));
    assign samp_byte  = (WHITEN != 0) ? (rand_in ^ prev_byte) : rand_in;
    // A completed word goes straight to the FIFO in its sampling cycle; it only parks in pack when full.
    assign word_dat   = held ? pack : {samp_byte, pack[23:0]};
    assign word_vld   = held ? collecting : (sample && last_byte);
    assign pop        = out_valid && out_ready;
    assign push       = word_vld && (!fifo_full || pop);
    assign flush      = abort && (state != IDLE);

    assign out_valid  = !fifo_empty;
    assign out_data   = out_valid ? head_dat : '0;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            byte_idx  <= '0;
            decim_cnt <= '0;
            prev_byte <= '0;
            pack      <= '0;
            held      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start && !abort) begin
                    if (req_words == '0) begin
                        done <= 1'b1;
                    end else begin
                        state     <= COLLECT;
                        remaining <= req_words;
                        byte_idx  <= '0;
                        decim_cnt <= '0;
                        held      <= 1'b0;
                    end
                end
            end else if (abort) begin
                state     <= IDLE;
                remaining <= '0;
                byte_idx  <= '0;
                decim_cnt <= '0;
                held      <= 1'b0;
            end else if (state == DRAIN) begin
                if (fifo_empty) begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
            end else begin
                if (!held) decim_cnt <= (decim_cnt == DECIM_LAST) ? '0 : decim_cnt + DW'(1);
                if (sample) begin
                    prev_byte                   <= rand_in;
                    byte_idx                    <= byte_idx + 2'd1;
                    pack[{byte_idx, 3'b000} +: 8] <= samp_byte;
                end
                if (word_vld) held <= !push;
                if (push && (remaining != '0)) begin
                    remaining <= remaining - WORDS_W'(1);
                    if (remaining == WORDS_W'(1)) state <= DRAIN;
                end
            end
        end
    end

    rng_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (word_dat),
        .pop       (pop),
        .flush     (flush),
        .head_data (head_dat),
        .level     (fifo_level),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );
endmodule

// File: tb/tb_rng_word_packer.sv
// Bench for rng_word_packer: queue-based reference model for the DECIM=1 instance, arithmetic model for DECIM=3/WHITEN=1.
module tb_rng_word_packer;
    localparam int DEPTH   = 8;
    localparam int M_DECIM = 1;
    localparam bit M_WHITEN = 1'b0;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rand_in, req_words;
    logic        start, abort, out_ready;
    logic        busy, done, out_valid;
    logic [31:0] out_data;
    logic [3:0]  fifo_level;

    logic [7:0]  rand_b, req_b;
    logic        start_b, abort_b, ready_b;
    logic        busy_b, done_b, valid_b;
    logic [31:0] data_b;
    logic [2:0]  level_b;

    rng_word_packer #(.DEPTH(DEPTH), .DECIM(1), .WHITEN(0), .WORDS_W(8)) dut (
        .clk(clk), .reset(reset), .rand_in(rand_in), .start(start), .req_words(req_words),
        .abort(abort), .busy(busy), .done(done), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_level(fifo_level));

    rng_word_packer #(.DEPTH(4), .DECIM(3), .WHITEN(1), .WORDS_W(8)) dut_b (
        .clk(clk), .reset(reset), .rand_in(rand_b), .start(start_b), .req_words(req_b),
        .abort(abort_b), .busy(busy_b), .done(done_b), .out_data(data_b), .out_valid(valid_b),
        .out_ready(ready_b), .fifo_level(level_b));

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model state for dut.
    bit          m_busy, m_drain, m_done, m_hold;
    int          m_rem, m_phase;
    logic [7:0]  m_prev;
    logic [7:0]  m_part[$];
    logic [31:0] m_fifo[$];
    logic [31:0] m_hold_word;
    logic [7:0]  pb_model;

    logic [38:0] dut_vec;
    assign dut_vec = {busy, done, out_valid, fifo_level, out_data};

    function automatic logic [38:0] exp_vec();
        logic [31:0] head;
        head = (m_fifo.size() > 0) ? m_fifo[0] : 32'h0;
        return {m_busy, m_done, (m_fifo.size() > 0), 4'(m_fifo.size()), head};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_drain = 0; m_done = 0; m_hold = 0;
        m_rem = 0; m_phase = 0; m_prev = 8'h00;
        m_part.delete(); m_fifo.delete();
    endtask

    task automatic model_edge();
        bit          pop, room, do_push;
        logic [7:0]  b;
        logic [31:0] w, pw;
        pop     = (m_fifo.size() > 0) && out_ready;
        room    = (m_fifo.size() < DEPTH) || pop;
        do_push = 0;
        pw      = 32'h0;
        m_done  = 0;
        if (!m_busy) begin
            if (start && !abort) begin
                if (req_words == 0) m_done = 1;
                else begin
                    m_busy = 1; m_drain = 0; m_rem = int'(req_words);
                    m_phase = 0; m_hold = 0; m_part.delete();
                end
            end
        end else if (abort) begin
            m_busy = 0; m_hold = 0; m_part.delete(); m_fifo.delete(); pop = 0;
        end else if (m_drain) begin
            if (m_fifo.size() == 0) begin m_done = 1; m_busy = 0; end
        end else if (m_hold) begin
            if (room) begin do_push = 1; pw = m_hold_word; m_hold = 0; end
        end else begin
            m_phase++;
            if (m_phase == M_DECIM) begin
                m_phase = 0;
                b = M_WHITEN ? (rand_in ^ m_prev) : rand_in;
                m_prev = rand_in;
                m_part.push_back(b);
                if (m_part.size() == 4) begin
                    w = {m_part[3], m_part[2], m_part[1], m_part[0]};
                    m_part.delete();
                    if (room) begin do_push = 1; pw = w; end
                    else begin m_hold = 1; m_hold_word = w; end
                end
            end
        end
        if (pop) void'(m_fifo.pop_front());
        if (do_push) begin
            m_fifo.push_back(pw);
            m_rem--;
            if (m_rem == 0) m_drain = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; model_reset();
        tick(); tick();
        checks++;
        if (dut_vec !== 39'h0) $display("FAIL reset_a: got %h want 0", dut_vec);
        else passed++;
        checks++;
        if ({busy_b, done_b, valid_b, level_b, data_b} !== 38'h0)
            $display("FAIL reset_b: got %h want 0", {busy_b, done_b, valid_b, level_b, data_b});
        else passed++;
        reset = 1'b0;
        tick();
        checks++;
        if (dut_vec !== exp_vec()) $display("FAIL reset_idle: got %h want %h", dut_vec, exp_vec());
        else passed++;
    endtask

    task automatic test_basic(input string tag);
        logic [31:0] got[$];
        int done_at, last_pop;
        done_at = -1; last_pop = -1;
        out_ready = 1'b1; req_words = 8'd2; start = 1'b1; rand_in = 8'h0F;
        for (int k = 0; k < 16; k++) begin
            tick();
            start = 1'b0; rand_in = 8'h10 + 8'(k);
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL %s_cyc%0d: got %h want %h", tag, k, dut_vec, exp_vec());
            else passed++;
            if (done && done_at < 0) done_at = k;
            if (out_valid && out_ready) begin got.push_back(out_data); last_pop = k + 1; end
        end
        checks++;
        if (got.size() != 2 || got[0] !== 32'h13121110 || got[1] !== 32'h17161514)
            $display("FAIL %s_words: got %0d words (%h %h) want 13121110 17161514", tag, got.size(),
                     (got.size() > 0) ? got[0] : 32'h0, (got.size() > 1) ? got[1] : 32'h0);
        else passed++;
        checks++;
        if (done_at != 10 || done_at != last_pop + 1)
            $display("FAIL %s_done_time: got edge %0d (last pop %0d) want edge 10", tag, done_at, last_pop);
        else passed++;
    endtask

    task automatic test_zero_req();
        logic [6:0] want[3];
        want[0] = 7'b0100000; want[1] = 7'b0; want[2] = 7'b0;
        out_ready = 1'b0; req_words = 8'd0; start = 1'b1; rand_in = 8'($urandom);
        for (int k = 0; k < 3; k++) begin
            tick();
            start = 1'b0;
            checks++;
            if ({busy, done, out_valid, fifo_level} !== want[k] || dut_vec !== exp_vec())
                $display("FAIL zero_req_cyc%0d: got %h want %h", k, dut_vec, exp_vec());
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        int pops;
        bit seen_done;
        pops = 0; seen_done = 0;
        out_ready = 1'b0; req_words = 8'd10; start = 1'b1; rand_in = 8'($urandom);
        for (int k = 0; k < 80; k++) begin
            tick();
            start = 1'b0; rand_in = 8'($urandom);
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL stall_cyc%0d: got %h want %h", k, dut_vec, exp_vec());
            else passed++;
        end
        checks++;
        if (fifo_level !== 4'd8 || busy !== 1'b1)
            $display("FAIL stall_full: got level %0d busy %b want level 8 busy 1", fifo_level, busy);
        else passed++;
        out_ready = 1'b1;
        for (int k = 0; k < 120 && !seen_done; k++) begin
            if (out_valid) pops++;
            tick();
            rand_in = 8'($urandom);
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL drain_cyc%0d: got %h want %h", k, dut_vec, exp_vec());
            else passed++;
            if (done) seen_done = 1;
        end
        checks++;
        if (pops != 10 || !seen_done)
            $display("FAIL stall_drain: got %0d pops done %b want 10 pops done 1", pops, seen_done);
        else passed++;
    endtask

    task automatic test_abort();
        logic [7:0]  r[5];
        logic [31:0] got;
        got = 32'h0;
        out_ready = 1'b0; req_words = 8'd5; start = 1'b1; rand_in = 8'($urandom);
        for (int k = 0; k <= 10; k++) begin
            tick();
            start = 1'b0; rand_in = 8'($urandom);
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL abort_pre%0d: got %h want %h", k, dut_vec, exp_vec());
            else passed++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({fifo_level, out_valid, busy, done} !== 7'h0 || dut_vec !== exp_vec())
            $display("FAIL abort_flush: got %h want %h", dut_vec, exp_vec());
        else passed++;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (done !== 1'b0 || dut_vec !== exp_vec()) $display("FAIL abort_idle%0d: got %h want %h", k, dut_vec, exp_vec());
            else passed++;
        end
        out_ready = 1'b1; req_words = 8'd1; start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            r[k < 5 ? k : 0] = (k < 5) ? 8'($urandom) : r[0];
            rand_in = r[k < 5 ? k : 0];
            tick();
            start = 1'b0;
            if (out_valid) got = out_data;
        end
        checks++;
        if (got !== {r[4], r[3], r[2], r[1]}) $display("FAIL abort_restart: got %h want %h", got, {r[4], r[3], r[2], r[1]});
        else passed++;
    endtask

    task automatic run_b(input bit directed, input int nwords, input string tag);
        logic [7:0]  s[];
        logic [31:0] expw[$];
        logic [31:0] got[$];
        logic [7:0]  raw;
        logic [31:0] w;
        bit seen_done;
        int n;
        n = 12 * nwords + 1;
        s = new[n];
        for (int k = 0; k < n; k++) s[k] = directed ? 8'(k) : 8'($urandom);
        for (int j = 0; j < nwords; j++) begin
            w = 32'h0;
            for (int b = 0; b < 4; b++) begin
                raw = s[3 * (4 * j + b + 1)];
                w[8 * b +: 8] = raw ^ pb_model;
                pb_model = raw;
            end
            expw.push_back(w);
        end
        seen_done = 0; ready_b = 1'b1; req_b = 8'(nwords);
        for (int k = 0; k < 12 * nwords + 10 && !seen_done; k++) begin
            rand_b = (k < n) ? s[k] : 8'($urandom);
            start_b = (k == 0);
            tick();
            start_b = 1'b0;
            if (valid_b) got.push_back(data_b);
            if (done_b) seen_done = 1;
        end
        checks++;
        if (!seen_done || busy_b !== 1'b0 || got.size() != nwords)
            $display("FAIL %s_done: got done %b busy %b words %0d want 1 0 %0d", tag, seen_done, busy_b, got.size(), nwords);
        else passed++;
        for (int j = 0; j < nwords && j < got.size(); j++) begin
            checks++;
            if (got[j] !== expw[j]) $display("FAIL %s_word%0d: got %h want %h", tag, j, got[j], expw[j]);
            else passed++;
        end
        if (directed) begin
            checks++;
            if (got.size() == 0 || got[0] !== 32'h050F0503)
                $display("FAIL %s_first: got %h want 050f0503", tag, (got.size() > 0) ? got[0] : 32'h0);
            else passed++;
        end
    endtask

    task automatic test_decim_whiten();
        pb_model = 8'h00;
        run_b(1'b1, 2, "whiten_dir");
        run_b(1'b0, 3, "whiten_rnd");
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; req_words = 8'd3; start = 1'b1; rand_in = 8'($urandom);
        for (int k = 0; k < 6; k++) begin
            tick();
            start = 1'b0; rand_in = 8'($urandom);
        end
        checks++;
        if (busy !== 1'b1 || fifo_level !== 4'd1) $display("FAIL areset_pre: got busy %b level %0d want 1 1", busy, fifo_level);
        else passed++;
        #2 reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (dut_vec !== 39'h0) $display("FAIL areset_now: got %h want 0", dut_vec);
        else passed++;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (dut_vec !== exp_vec()) $display("FAIL areset_idle: got %h want %h", dut_vec, exp_vec());
        else passed++;
        test_basic("after_reset");
    endtask

    initial begin
        rand_in = 8'h00; req_words = 8'h00; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        rand_b = 8'h00; req_b = 8'h00; start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b0;
        test_reset();
        test_basic("basic");
        test_zero_req();
        test_backpressure();
        test_abort();
        test_decim_whiten();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
